ex_stage_booth: RTL and testbench
=================================

# ex_stage_booth

Execute stage of the 32-bit pipelined MIPS core, sitting directly upstream of the EX/MEM pipeline register. It computes the ALU result, zero flag and branch target for single-cycle operations. Signed multiplication is handled by a multicycle radix-2 Booth sequencer that stalls the front of the pipeline until the product is ready. Its `hit` output is the valid/advance qualifier the EX/MEM register samples; register-file data and control bits for EX/MEM bypass this block.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; the Booth step count equals `WIDTH`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `valid_in`, input, 1: an instruction is present at the stage inputs.
- `pcPlus4`, input, 32: PC+4 of the instruction.
- `readData1`, input, 32: operand A.
- `readData2`, input, 32: register operand B.
- `signExtImm`, input, 32: sign-extended immediate.
- `ALUSrc`, input, 1: 1 selects `signExtImm` as operand B, 0 selects `readData2`.
- `ALUControl`, input, 4: operation select.
- `ALUResult`, output, 32: result to EX/MEM.
- `zeroFlag`, output, 1: `ALUResult == 0`.
- `branchTarget`, output, 32: `pcPlus4 + (signExtImm << 2)`, truncated to 32 bits.
- `hiOut`, output, 32: upper half of the last completed product.
- `hit`, output, 1: outputs are valid this cycle; EX/MEM may capture.
- `stall`, output, 1: upstream stages must hold their current instruction.

## Operation
- Operand B: `B = ALUSrc ? signExtImm : readData2`.
- `ALUControl` encodings:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (wrapping arithmetic).
  - 0111 SLT: signed compare, result is 1 or 0.
  - 1100 NOR.
  - 1000 MUL: signed A×B.
  - Any other code gives result 0.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - Non-MUL with `valid_in=1`: `hit=1`, `stall=0`, combinational ALU result; stay in IDLE.
  - `valid_in=0`: `hit=0`, `stall=0`.
  - MUL with `valid_in=1`: `hit=0` and `stall=1` combinationally. On the clock edge:
    - load M=A (sign-extended to 33 bits);
    - set Q=B, Q_1=0, Acc=0 (33 bits), count=0;
    - go to MUL.
- MUL: `stall=1`, `hit=0`. Each cycle performs one Booth step:
  - `{Q[0],Q_1}`=01: Acc+=M; 10: Acc-=M; 00 or 11: no add.
  - Then arithmetic-shift-right `{Acc,Q,Q_1}` by one.
  - count++.
  - After the step with count==WIDTH-1, go to DONE and latch `hiOut` = Acc[31:0].
  - The 33-bit Acc makes A=−2^31 exact.
- DONE: `hit=1`, `stall=0`, `ALUResult=Q` (low product word), `zeroFlag` from that value. Go to IDLE unconditionally; the MUL still presented at `valid_in` is not restarted.
- `branchTarget` is combinational in every state. During MUL/DONE it uses the live `pcPlus4`/`signExtImm`, which upstream holds stable because of the stall.
- `hiOut` changes only on MUL completion.

## Timing
- Single-cycle ops: zero latency. `hit` is valid in the same cycle as `valid_in`, ahead of the EX/MEM negedge capture.
- MUL latency:
  - cycle 0 is acceptance (IDLE);
  - cycles 1..32 are Booth steps;
  - cycle 33 is DONE with `hit=1`;
  - `stall=1` in cycles 0..32.
- Back-to-back MULs: the second MUL is accepted in the IDLE cycle following DONE, so there is one bubble-free IDLE.
- Reset (asynchronous, any state including mid-multiply):
  - state=IDLE, count=0, Acc/Q/Q_1/M=0, `hiOut`=0;
  - `hit=0` and `stall=0` while `rst=1`;
  - an aborted product is discarded, not completed.
- `valid_in` dropping during MUL/DONE is ignored; the operands were captured at acceptance.

## Test plan
- ADD, `readData1`=5, `readData2`=7, `ALUSrc`=0, `valid_in`=1 -> same cycle `ALUResult`=12, `zeroFlag`=0, `hit`=1, `stall`=0.
- SUB 9−9 with `pcPlus4`=0x100, `signExtImm`=0xFFFFFFFF -> `ALUResult`=0, `zeroFlag`=1, `branchTarget`=0xFC.
- SLT −1 vs 1 -> 1; SLT 1 vs −1 -> 0; `ALUControl`=1111 -> 0.
- MUL −3×7 -> `stall` high for 33 cycles, `hit` only in cycle 33 with `ALUResult`=0xFFFFFFEB, then `hiOut`=0xFFFFFFFF.
- MUL 0x80000000×0x80000000 -> `ALUResult`=0, `zeroFlag`=1, `hiOut`=0x40000000; then ADD 1+1 next cycle -> 2.
- Assert `rst` at step 10 of MUL 6×6 -> immediate `stall`=0, `hit`=0, `hiOut`=0. After release, a fresh MUL 6×6 -> 36 at cycle 33.

Source files
------------

// File: rtl/ex_stage_booth_if.sv
// Operand/control bundle into the execute stage and its result/handshake
// bundle towards EX/MEM and the hazard logic.
interface ex_stage_booth_if #(parameter int WIDTH = 32) ();
    logic             valid_in;
    logic [WIDTH-1:0] pcPlus4;
    logic [WIDTH-1:0] readData1;
    logic [WIDTH-1:0] readData2;
    logic [WIDTH-1:0] signExtImm;
    logic             ALUSrc;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] ALUResult;
    logic             zeroFlag;
    logic [WIDTH-1:0] branchTarget;
    logic [WIDTH-1:0] hiOut;
    logic             hit;
    logic             stall;

    modport master (
        output valid_in, pcPlus4, readData1, readData2, signExtImm, ALUSrc, ALUControl,
        input  ALUResult, zeroFlag, branchTarget, hiOut, hit, stall
    );

    modport slave (
        input  valid_in, pcPlus4, readData1, readData2, signExtImm, ALUSrc, ALUControl,
        output ALUResult, zeroFlag, branchTarget, hiOut, hit, stall
    );
endinterface

// File: rtl/ex_stage_booth.sv
// MIPS execute stage: single-cycle ALU plus a radix-2 Booth multiplier that
// stalls the front of the pipeline for WIDTH steps.
module ex_stage_booth #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    ex_stage_booth_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH:0]   r_m;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic [WIDTH-1:0] r_hi;

    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_result;
    logic               w_is_mul;
    logic               w_accept;
    logic [WIDTH:0]     w_acc_sum;
    logic [2*WIDTH+1:0] w_shifted;

    assign w_b      = bus.ALUSrc ? bus.signExtImm : bus.readData2;
    assign w_is_mul = (bus.ALUControl == OP_MUL);
    assign w_accept = (r_state == S_IDLE) && bus.valid_in && w_is_mul;

    always_comb begin
        w_alu = '0;
        case (bus.ALUControl)
            OP_AND:  w_alu = bus.readData1 & w_b;
            OP_OR:   w_alu = bus.readData1 | w_b;
            OP_ADD:  w_alu = bus.readData1 + w_b;
            OP_SUB:  w_alu = bus.readData1 - w_b;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.readData1) < $signed(w_b))};
            OP_NOR:  w_alu = ~(bus.readData1 | w_b);
            default: w_alu = '0;
        endcase
    end

    // Booth recoding of {Q[0],Q_1}; the extra Acc bit keeps M = -2^(WIDTH-1) exact.
    always_comb begin
        w_acc_sum = r_acc;
        case ({r_q[0], r_q1})
            2'b01:   w_acc_sum = r_acc + r_m;
            2'b10:   w_acc_sum = r_acc - r_m;
            default: w_acc_sum = r_acc;
        endcase
    end

    // Arithmetic shift of {Acc,Q,Q_1}: old Q[0] becomes the new Q_1.
    assign w_shifted = {w_acc_sum[WIDTH], w_acc_sum, r_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_hi    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_m     <= {bus.readData1[WIDTH-1], bus.readData1};
                        r_q     <= w_b;
                        r_q1    <= 1'b0;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    {r_acc, r_q, r_q1} <= w_shifted;
                    r_count            <= r_count + 1'b1;
                    if (r_count == LAST_STEP) begin
                        r_state <= S_DONE;
                        r_hi    <= w_shifted[2*WIDTH:WIDTH+1];
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_result         = (r_state == S_DONE) ? r_q : w_alu;
    assign bus.ALUResult    = w_result;
    assign bus.zeroFlag     = (w_result == '0);
    assign bus.branchTarget = bus.pcPlus4 + {bus.signExtImm[WIDTH-3:0], 2'b00};
    assign bus.hiOut        = r_hi;
    assign bus.hit   = !rst && (((r_state == S_IDLE) && bus.valid_in && !w_is_mul)
                                || (r_state == S_DONE));
    assign bus.stall = !rst && (w_accept || (r_state == S_MUL));
endmodule

// File: tb/tb_ex_stage_booth.sv
// Randomized self-checking bench for ex_stage_booth against an arithmetic
// reference model (plain operators and a 64-bit signed product).
module tb_ex_stage_booth;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_booth_if #(.WIDTH(32)) bus ();
    ex_stage_booth #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi;

    function automatic logic [31:0] ref_alu(logic [3:0] c, logic [31:0] a, logic [31:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(logic v, logic [3:0] c, logic [31:0] a, logic [31:0] rd2,
                         logic [31:0] imm, logic [31:0] pc, logic src);
        bus.valid_in   = v;
        bus.ALUControl = c;
        bus.readData1  = a;
        bus.readData2  = rd2;
        bus.signExtImm = imm;
        bus.pcPlus4    = pc;
        bus.ALUSrc     = src;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 4'b0010, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", bus.hit); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
        checks++; if (bus.hiOut !== 32'd0) begin errors++; $display("FAIL reset_hiOut: got %h expected 0", bus.hiOut); end
        bus.ALUControl = 4'b1000;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_mul_stall: got %b expected 0", bus.stall); end
        @(negedge clk);
        rst = 1'b0;
        bus.valid_in = 1'b0;
        #1;
        checks++; if (bus.hit !== 1'b0 || bus.stall !== 1'b0) begin
            errors++; $display("FAIL idle_novalid: got hit=%b stall=%b expected 0/0", bus.hit, bus.stall);
        end
        exp_hi = 32'd0;
        $display("reset: hit=%b stall=%b hiOut=%h", bus.hit, bus.stall, bus.hiOut);
    endtask

    task automatic test_alu_directed;
        logic [3:0]  t_c   [0:6];
        logic [31:0] t_a   [0:6];
        logic [31:0] t_rd2 [0:6];
        logic [31:0] t_imm [0:6];
        logic [31:0] t_pc  [0:6];
        logic        t_src [0:6];
        logic [31:0] t_res [0:6];
        logic [31:0] t_bt  [0:6];
        t_c   = '{4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b1111, 4'b0010, 4'b1100};
        t_a   = '{32'd5, 32'd9, 32'hFFFFFFFF, 32'd1, 32'd5, 32'd10, 32'd0};
        t_rd2 = '{32'd7, 32'd9, 32'd1, 32'hFFFFFFFF, 32'd7, 32'd99, 32'd0};
        t_imm = '{32'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFE, 32'd3};
        t_pc  = '{32'd0, 32'h100, 32'd0, 32'd0, 32'd0, 32'h200, 32'h40};
        t_src = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        t_res = '{32'd12, 32'd0, 32'd1, 32'd0, 32'd0, 32'd8, 32'hFFFFFFFF};
        t_bt  = '{32'd0, 32'hFC, 32'd0, 32'd0, 32'd0, 32'h1F8, 32'h4C};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(1'b1, t_c[i], t_a[i], t_rd2[i], t_imm[i], t_pc[i], t_src[i]);
            #1;
            checks++; if (bus.ALUResult !== t_res[i]) begin errors++; $display("FAIL dir_result[%0d]: got %h expected %h", i, bus.ALUResult, t_res[i]); end
            checks++; if (bus.zeroFlag !== (t_res[i] == 32'd0)) begin errors++; $display("FAIL dir_zero[%0d]: got %b expected %b", i, bus.zeroFlag, t_res[i] == 32'd0); end
            checks++; if (bus.branchTarget !== t_bt[i]) begin errors++; $display("FAIL dir_branch[%0d]: got %h expected %h", i, bus.branchTarget, t_bt[i]); end
            checks++; if (bus.hit !== 1'b1 || bus.stall !== 1'b0) begin errors++; $display("FAIL dir_handshake[%0d]: got hit=%b stall=%b expected 1/0", i, bus.hit, bus.stall); end
            $display("alu op=%b a=%h b=%h -> %h", t_c[i], t_a[i], t_src[i] ? t_imm[i] : t_rd2[i], bus.ALUResult);
        end
    endtask

    task automatic test_alu_random;
        logic [3:0]  ops [0:5];
        logic [3:0]  c;
        logic [31:0] a, rd2, imm, pc, b, res, bt;
        logic        src, v;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        for (int i = 0; i < 40; i++) begin
            c = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 5)];
            if (c == 4'b1000) c = 4'b1111;
            a = $urandom; rd2 = $urandom; imm = $urandom; pc = $urandom;
            if ($urandom_range(0, 5) == 0) rd2 = a;
            src = 1'($urandom_range(0, 1));
            v   = ($urandom_range(0, 7) != 0);
            b   = src ? imm : rd2;
            res = ref_alu(c, a, b);
            bt  = pc + (imm << 2);
            @(negedge clk);
            drive(v, c, a, rd2, imm, pc, src);
            #1;
            checks++; if (bus.branchTarget !== bt) begin errors++; $display("FAIL rnd_branch[%0d]: got %h expected %h", i, bus.branchTarget, bt); end
            checks++; if (bus.hit !== v || bus.stall !== 1'b0) begin errors++; $display("FAIL rnd_handshake[%0d]: got hit=%b stall=%b expected %b/0", i, bus.hit, bus.stall, v); end
            if (v) begin
                checks++; if (bus.ALUResult !== res) begin errors++; $display("FAIL rnd_result[%0d]: op=%b got %h expected %h", i, c, bus.ALUResult, res); end
                checks++; if (bus.zeroFlag !== (res == 32'd0)) begin errors++; $display("FAIL rnd_zero[%0d]: got %b expected %b", i, bus.zeroFlag, res == 32'd0); end
            end
            $display("alu rnd v=%b op=%b a=%h b=%h -> %h", v, c, a, b, bus.ALUResult);
        end
    endtask

    // Runs one multiply from acceptance through DONE, checking every cycle.
    task automatic run_mul(logic [31:0] a, logic [31:0] b);
        logic signed [63:0] p;
        logic [31:0] lo, hi, rd2, imm, pc, bt;
        logic        src;
        int          stall_cycles;
        p  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        lo = p[31:0];
        hi = p[63:32];
        src = 1'($urandom_range(0, 1));
        rd2 = src ? 32'($urandom) : b;
        imm = src ? b : 32'($urandom);
        pc  = $urandom;
        bt  = pc + (imm << 2);
        stall_cycles = 0;
        @(negedge clk);
        drive(1'b1, 4'b1000, a, rd2, imm, pc, src);
        #1;
        if (bus.stall === 1'b1) stall_cycles++;
        checks++; if (bus.hit !== 1'b0 || bus.stall !== 1'b1) begin errors++; $display("FAIL mul_accept: got hit=%b stall=%b expected 0/1", bus.hit, bus.stall); end
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            bus.valid_in  = 1'($urandom_range(0, 1));
            bus.readData1 = $urandom;
            bus.readData2 = $urandom;
            bus.ALUSrc    = 1'($urandom_range(0, 1));
            #1;
            if (bus.stall === 1'b1) stall_cycles++;
            checks++; if (bus.hit !== 1'b0 || bus.stall !== 1'b1) begin errors++; $display("FAIL mul_step[%0d]: got hit=%b stall=%b expected 0/1", k, bus.hit, bus.stall); end
            if (k == 32) begin
                checks++; if (bus.hiOut !== exp_hi) begin errors++; $display("FAIL mul_hi_early: got %h expected %h", bus.hiOut, exp_hi); end
                checks++; if (bus.branchTarget !== bt) begin errors++; $display("FAIL mul_branch: got %h expected %h", bus.branchTarget, bt); end
            end
        end
        @(negedge clk);
        drive(1'b1, 4'b1000, a, rd2, imm, pc, src);
        #1;
        checks++; if (stall_cycles != 33) begin errors++; $display("FAIL mul_stall_len: got %0d expected 33", stall_cycles); end
        checks++; if (bus.hit !== 1'b1 || bus.stall !== 1'b0) begin errors++; $display("FAIL mul_done: got hit=%b stall=%b expected 1/0", bus.hit, bus.stall); end
        checks++; if (bus.ALUResult !== lo) begin errors++; $display("FAIL mul_lo: got %h expected %h", bus.ALUResult, lo); end
        checks++; if (bus.zeroFlag !== (lo == 32'd0)) begin errors++; $display("FAIL mul_zero: got %b expected %b", bus.zeroFlag, lo == 32'd0); end
        checks++; if (bus.hiOut !== hi) begin errors++; $display("FAIL mul_hi: got %h expected %h", bus.hiOut, hi); end
        exp_hi = hi;
        $display("mul a=%h b=%h -> hi=%h lo=%h", a, b, bus.hiOut, bus.ALUResult);
    endtask

    task automatic test_mul_directed;
        run_mul(32'hFFFFFFFD, 32'd7);
        run_mul(32'h80000000, 32'h80000000);
        @(negedge clk);
        drive(1'b1, 4'b0010, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0);
        #1;
        checks++; if (bus.ALUResult !== 32'd2 || bus.hit !== 1'b1 || bus.stall !== 1'b0) begin
            errors++; $display("FAIL add_after_mul: got res=%h hit=%b stall=%b expected 2/1/0", bus.ALUResult, bus.hit, bus.stall);
        end
        checks++; if (bus.hiOut !== 32'h40000000) begin errors++; $display("FAIL hi_hold: got %h expected 40000000", bus.hiOut); end
        $display("add after mul: 1+1 -> %h", bus.ALUResult);
    endtask

    task automatic test_back_to_back;
        run_mul($urandom, $urandom);
        run_mul($urandom, $urandom);
        run_mul(32'h7FFFFFFF, 32'h80000000);
    endtask

    task automatic test_reset_mid_mul;
        @(negedge clk);
        drive(1'b1, 4'b1000, 32'd6, 32'd6, 32'd0, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.hit !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL abort_handshake: got hit=%b stall=%b expected 0/0", bus.hit, bus.stall); end
        checks++; if (bus.hiOut !== 32'd0) begin errors++; $display("FAIL abort_hiOut: got %h expected 0", bus.hiOut); end
        exp_hi = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        bus.valid_in = 1'b0;
        #1;
        checks++; if (bus.hit !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL abort_idle: got hit=%b stall=%b expected 0/0", bus.hit, bus.stall); end
        $display("reset mid-mul: hit=%b stall=%b hiOut=%h", bus.hit, bus.stall, bus.hiOut);
        run_mul(32'd6, 32'd6);
    endtask

    task automatic test_mul_random;
        for (int i = 0; i < 4; i++) run_mul($urandom, 32'($signed(16'($urandom))));
        run_mul(32'd0, $urandom);
    endtask

    initial begin
        test_reset;
        test_alu_directed;
        test_alu_random;
        test_mul_directed;
        test_back_to_back;
        test_reset_mid_mul;
        test_mul_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
